cmult_seq: RTL

Parametrised, handshaked complex multiplier for the FFT/OFDM datapath. It computes either (a·b) or (a·conj(b)) with a compile-time number of physical multipliers (1, 2 or 4), so area can be traded against throughput. It has a valid/ready input, a valid/ready output with backpressure, an optional conjugate mode per transaction, and configurable output scaling. It sits between the twiddle/pilot ROM stage and the butterfly/equaliser stages.

---
 rtl/cmult_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/cmult_seq.sv
// Handshaked complex multiplier (a*b or a*conj(b)) with 1, 2 or 4 time-shared multipliers.
// Define CMULT_ROUND_SAT_EN for round-half-up scaling and output saturation; otherwise truncate and wrap.
module cmult_seq #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 17,
  parameter int NUM_MULT  = 1,
  parameter int MULT_LAT  = 2,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_W     = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] a_q,
  input  logic signed [COEF_W-1:0] b_i,
  input  logic signed [COEF_W-1:0] b_q,
  input  logic                     in_conj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_i,
  output logic signed [OUT_W-1:0]  out_q,
  output logic                     out_sat
);

  localparam int K     = 4 / NUM_MULT;
  localparam int P_W   = DATA_W + COEF_W;
  localparam int S_W   = P_W + 1;
  localparam int X_W   = ((S_W > OUT_W) ? S_W : OUT_W) + 2;
  localparam int CNT_W = $clog2(MULT_LAT + 4);
  localparam logic [1:0] STEP = 2'(NUM_MULT);

  if (!(NUM_MULT == 1 || NUM_MULT == 2 || NUM_MULT == 4)) begin : g_bad_num_mult
    $error("cmult_seq: NUM_MULT must be 1, 2 or 4");
  end
  if (MULT_LAT < 1) begin : g_bad_mult_lat
    $error("cmult_seq: MULT_LAT must be at least 1");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_SUM, ST_OUT} state_t;

  state_t                     r_state, w_state_next;
  logic [CNT_W-1:0]           r_cnt, w_cnt_next;
  logic signed [DATA_W-1:0]   r_a_i, r_a_q;
  logic signed [COEF_W-1:0]   r_b_i, r_b_q;
  logic                       r_conj;
  logic [MULT_LAT-1:0]        r_tag_vld;
  logic [1:0]                 r_tag_c [MULT_LAT];
  logic [NUM_MULT-1:0][P_W-1:0] w_lane_prod;
  logic signed [P_W-1:0]      r_prod [4];
  logic signed [OUT_W-1:0]    r_out_i, r_out_q;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_OUT);
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: if (in_valid) begin
        w_state_next = ST_ISSUE;
        w_cnt_next   = '0;
      end
      ST_ISSUE: if (r_cnt == CNT_W'(K - 1)) begin
        w_state_next = ST_WAIT;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
      ST_WAIT: if (r_cnt == CNT_W'(MULT_LAT - 1)) begin
        w_state_next = ST_SUM;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
      ST_SUM:  w_state_next = ST_OUT;
      ST_OUT:  if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_i  <= '0;
      r_a_q  <= '0;
      r_b_i  <= '0;
      r_b_q  <= '0;
      r_conj <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_a_i  <= a_i;
      r_a_q  <= a_q;
      r_b_i  <= b_i;
      r_b_q  <= b_q;
      r_conj <= in_conj;
    end
  end

  // Product index p: 0=ii 1=qq 2=iq 3=qi; a uses q when p is odd, b uses q for qq/iq.
  for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_lane
    localparam logic [1:0] LANE_P = 2'(gi);
    logic [1:0]              w_pidx;
    logic signed [DATA_W-1:0] r_x;
    logic signed [COEF_W-1:0] r_y;
    logic signed [P_W-1:0]    w_mul;

    assign w_pidx = LANE_P + r_cnt[1:0] * STEP;
    assign w_mul  = P_W'(r_x) * P_W'(r_y);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x <= '0;
        r_y <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_x <= w_pidx[0] ? r_a_q : r_a_i;
        r_y <= (w_pidx[0] ^ w_pidx[1]) ? r_b_q : r_b_i;
      end
    end

    if (MULT_LAT == 1) begin : g_comb
      assign w_lane_prod[gi] = w_mul;
    end else begin : g_pipe
      logic signed [P_W-1:0] r_pp [1:MULT_LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 1; k < MULT_LAT; k++) r_pp[k] <= '0;
        end else begin
          r_pp[1] <= w_mul;
          for (int k = 2; k < MULT_LAT; k++) r_pp[k] <= r_pp[k-1];
        end
      end
      assign w_lane_prod[gi] = r_pp[MULT_LAT-1];
    end
  end

  // Issue-cycle tag travels alongside the multiplier pipeline to steer each result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int k = 0; k < MULT_LAT; k++) r_tag_c[k] <= '0;
      for (int p = 0; p < 4; p++) r_prod[p] <= '0;
    end else begin
      r_tag_vld[0] <= (r_state == ST_ISSUE);
      r_tag_c[0]   <= r_cnt[1:0];
      for (int k = 1; k < MULT_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_c[k]   <= r_tag_c[k-1];
      end
      if (r_tag_vld[MULT_LAT-1]) begin
        for (int l = 0; l < NUM_MULT; l++)
          r_prod[2'(l) + r_tag_c[MULT_LAT-1] * STEP] <= w_lane_prod[l];
      end
    end
  end

  logic signed [X_W-1:0] w_ii, w_qq, w_iq, w_qi, w_re, w_im;
  logic signed [OUT_W-1:0] w_res_re, w_res_im;

  assign w_ii = X_W'(r_prod[0]);
  assign w_qq = X_W'(r_prod[1]);
  assign w_iq = X_W'(r_prod[2]);
  assign w_qi = X_W'(r_prod[3]);
  assign w_re = r_conj ? (w_ii + w_qq) : (w_ii - w_qq);
  assign w_im = r_conj ? (w_qi - w_iq) : (w_iq + w_qi);

`ifdef CMULT_ROUND_SAT_EN
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [X_W-1:0] RND_K   = (OUT_SHIFT > 0) ? (X_W'(1) << RND_SH) : '0;
  localparam logic signed [X_W-1:0] SAT_MAX = {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [X_W-1:0] SAT_MIN = {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W:0] fit_sat(input logic signed [X_W-1:0] v);
    if (v > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] w_fit_re, w_fit_im;
  logic           r_sat;

  assign w_fit_re = fit_sat((w_re + RND_K) >>> OUT_SHIFT);
  assign w_fit_im = fit_sat((w_im + RND_K) >>> OUT_SHIFT);
  assign w_res_re = w_fit_re[OUT_W-1:0];
  assign w_res_im = w_fit_im[OUT_W-1:0];
  assign out_sat  = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sat <= 1'b0;
    else if (r_state == ST_SUM) r_sat <= w_fit_re[OUT_W] | w_fit_im[OUT_W];
  end
`else
  logic signed [X_W-1:0] w_re_sh, w_im_sh;
  logic                  w_unused;

  assign w_re_sh  = w_re >>> OUT_SHIFT;
  assign w_im_sh  = w_im >>> OUT_SHIFT;
  assign w_res_re = w_re_sh[OUT_W-1:0];
  assign w_res_im = w_im_sh[OUT_W-1:0];
  assign w_unused = ^{w_re_sh[X_W-1:OUT_W], w_im_sh[X_W-1:OUT_W]};
  assign out_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_i <= '0;
      r_out_q <= '0;
    end else if (r_state == ST_SUM) begin
      r_out_i <= w_res_re;
      r_out_q <= w_res_im;
    end
  end

endmodule
